// File: rtl/pipe_cla_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_cla_pkg
// Description : Shared constants and parameter legality check for the
//               pipelined carry-lookahead adder.
//               No ports (package).
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_cla_pkg;

    localparam int CLA_GROUP      = 4;
    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_STAGES = 2;

    // True when WIDTH splits into STAGES equal slices of whole 4-bit groups.
    function automatic bit params_legal(input int width, input int stages);
        if (width <= 0 || (width % CLA_GROUP) != 0) begin
            return 1'b0;
        end
        if (stages < 1 || stages > (width / CLA_GROUP)) begin
            return 1'b0;
        end
        return (width % (stages * CLA_GROUP)) == 0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla_group.sv
`default_nettype none
// ============================================================================
// Module      : cla_group
// Description : Combinational 4-bit carry-lookahead group.
//   i_g, i_p : per-bit generate / propagate
//   i_cin    : carry into bit 0 of the group
//   o_c      : carry into each of the four bits (o_c[0] == i_cin)
//   o_gg     : group generate
//   o_gp     : group propagate
// Revision    : 1.0 - initial release
// ============================================================================
module cla_group
    import pipe_cla_pkg::*;
(
    input  logic [CLA_GROUP-1:0] i_g,
    input  logic [CLA_GROUP-1:0] i_p,
    input  logic                 i_cin,
    output logic [CLA_GROUP-1:0] o_c,
    output logic                 o_gg,
    output logic                 o_gp
);

    // Every carry is a flat sum of products of g/p and the group carry-in,
    // so no bit waits on the carry of its neighbour.
    assign o_c[0] = i_cin;
    assign o_c[1] = i_g[0] | (i_p[0] & i_cin);
    assign o_c[2] = i_g[1] | (i_p[1] & i_g[0]) | (i_p[1] & i_p[0] & i_cin);
    assign o_c[3] = i_g[2] | (i_p[2] & i_g[1]) | (i_p[2] & i_p[1] & i_g[0])
                  | (i_p[2] & i_p[1] & i_p[0] & i_cin);

    assign o_gg = i_g[3] | (i_p[3] & i_g[2]) | (i_p[3] & i_p[2] & i_g[1])
                | (i_p[3] & i_p[2] & i_p[1] & i_g[0]);
    assign o_gp = &i_p;

endmodule
`default_nettype wire

// File: rtl/pipe_cla_adder.sv
`default_nettype none
// ============================================================================
// Module      : pipe_cla_adder
// Description : Pipelined add/subtract built from 4-bit carry-lookahead
//               groups. Each of STAGES stages adds one WIDTH/STAGES slice;
//               the carry between slices is registered.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (a, b, cin, sub)
//   out_valid/out_ready : result handshake (sum, cout, ovf, zero)
//   sub=1 computes a + ~b + 1 (cin ignored); cout=1 then means no borrow.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_cla_adder
    import pipe_cla_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int SW = WIDTH / STAGES;      // slice width per stage
    localparam int NG = SW / CLA_GROUP;      // CLA groups per slice

    if (!params_legal(WIDTH, STAGES)) begin : g_param_check
        $fatal(1, "pipe_cla_adder: WIDTH must be a multiple of STAGES*4 and STAGES in 1..WIDTH/4");
    end

    logic             w_en;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    // Whole pipeline moves together: it may advance whenever the output
    // register is empty or being drained this cycle.
    assign w_en     = ~r_out_valid | out_ready;
    assign in_ready = w_en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still to be added at this stage, including its own slice.
        localparam int REM = WIDTH - k * SW;

        logic [REM-1:0]        w_a;
        logic [REM-1:0]        w_b;
        logic                  w_cin;
        logic                  w_v;
        logic [SW-1:0]         w_p;
        logic [SW-1:0]         w_g;
        logic [SW-1:0]         w_bit_c;
        logic [SW-1:0]         w_s;
        logic [NG:0]           w_grp_c;
        logic [(k+1)*SW-1:0]   w_acc;   // finished low slices plus this one

        if (k == 0) begin : g_src
            // Subtraction folds into the adder as inverted B with carry-in 1.
            assign w_a   = a;
            assign w_b   = sub ? ~b : b;
            assign w_cin = sub | cin;
            assign w_v   = in_valid;
            assign w_acc = w_s;
        end else begin : g_src
            logic [REM-1:0]  r_a;
            logic [REM-1:0]  r_b;
            logic [k*SW-1:0] r_lo;
            logic            r_c;
            logic            r_v;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v  <= 1'b0;
                    r_c  <= 1'b0;
                    r_a  <= '0;
                    r_b  <= '0;
                    r_lo <= '0;
                end else if (w_en) begin
                    r_v  <= g_stage[k-1].w_v;
                    r_c  <= g_stage[k-1].w_grp_c[NG];
                    r_a  <= g_stage[k-1].w_a[SW +: REM];
                    r_b  <= g_stage[k-1].w_b[SW +: REM];
                    r_lo <= g_stage[k-1].w_acc;
                end
            end

            assign w_a   = r_a;
            assign w_b   = r_b;
            assign w_cin = r_c;
            assign w_v   = r_v;
            assign w_acc = {w_s, r_lo};
        end

        assign w_p        = w_a[SW-1:0] ^ w_b[SW-1:0];
        assign w_g        = w_a[SW-1:0] & w_b[SW-1:0];
        assign w_grp_c[0] = w_cin;

        // Groups resolve their internal carries in parallel; only the group
        // carry-out is chained to the next group.
        for (genvar j = 0; j < NG; j++) begin : g_grp
            logic w_gg;
            logic w_gp;

            cla_group u_cla (
                .i_g   (w_g[j*CLA_GROUP +: CLA_GROUP]),
                .i_p   (w_p[j*CLA_GROUP +: CLA_GROUP]),
                .i_cin (w_grp_c[j]),
                .o_c   (w_bit_c[j*CLA_GROUP +: CLA_GROUP]),
                .o_gg  (w_gg),
                .o_gp  (w_gp)
            );

            assign w_grp_c[j+1] = w_gg | (w_gp & w_grp_c[j]);
        end

        assign w_s = w_p ^ w_bit_c;
    end

    // Output register: the last slice's bit carry into the MSB against the
    // final carry-out gives signed overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_en) begin
            r_out_valid <= g_stage[STAGES-1].w_v;
            r_sum       <= g_stage[STAGES-1].w_acc;
            r_cout      <= g_stage[STAGES-1].w_grp_c[NG];
            r_ovf       <= g_stage[STAGES-1].w_bit_c[SW-1] ^ g_stage[STAGES-1].w_grp_c[NG];
            r_zero      <= ~|g_stage[STAGES-1].w_acc;
        end
    end

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_pipe_cla_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pipe_cla_adder
// Description : Scoreboard bench for pipe_cla_adder. dut0 is 16-bit/2-stage,
//               dut1 is 32-bit/4-stage. Drivers push expected results into
//               per-DUT queues; negedge monitors compare whatever the DUT
//               presents against the queue head.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_cla_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        bit          lat;
        int          acc;
        bit          seen;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    logic        in_valid0, in_ready0, cin0, sub0, out_valid0, out_ready0, cout0, ovf0, zero0;
    logic [15:0] a0, b0, sum0;
    logic        in_valid1, in_ready1, cin1, sub1, out_valid1, out_ready1, cout1, ovf1, zero1;
    logic [31:0] a1, b1, sum1;

    pipe_cla_adder #(.WIDTH(16), .STAGES(2)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .a(a0), .b(b0), .cin(cin0), .sub(sub0),
        .out_valid(out_valid0), .out_ready(out_ready0),
        .sum(sum0), .cout(cout0), .ovf(ovf0), .zero(zero0)
    );

    pipe_cla_adder #(.WIDTH(32), .STAGES(4)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .sub(sub1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .ovf(ovf1), .zero(zero1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!rst && out_valid0) begin
            if (q0.size() == 0) begin
                fail_now("dut0_unexpected_result");
            end else begin
                check("dut0_sum",  32'(sum0),  q0[0].sum);
                check("dut0_cout", 32'(cout0), 32'(q0[0].cout));
                check("dut0_ovf",  32'(ovf0),  32'(q0[0].ovf));
                check("dut0_zero", 32'(zero0), 32'(q0[0].zero));
                if (q0[0].lat && !q0[0].seen)
                    check("dut0_latency", 32'(cyc + 1 - q0[0].acc), 32'd2);
                q0[0].seen = 1'b1;
                if (out_ready0) void'(q0.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid1) begin
            if (q1.size() == 0) begin
                fail_now("dut1_unexpected_result");
            end else begin
                check("dut1_sum",  sum1,        q1[0].sum);
                check("dut1_cout", 32'(cout1),  32'(q1[0].cout));
                check("dut1_ovf",  32'(ovf1),   32'(q1[0].ovf));
                check("dut1_zero", 32'(zero1),  32'(q1[0].zero));
                if (q1[0].lat && !q1[0].seen)
                    check("dut1_latency", 32'(cyc + 1 - q1[0].acc), 32'd4);
                q1[0].seen = 1'b1;
                if (out_ready1) void'(q1.pop_front());
            end
        end
    end

    bit rand_rdy = 1'b0;
    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready1 = ($urandom_range(0, 3) != 0);
    end

    // ---------------- drivers ----------------
    task automatic send0(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic s,
                         input logic [15:0] es, input logic ec, input logic eo, input logic ez,
                         input bit lat);
        exp_t e;
        int   w;
        a0 = a; b0 = b; cin0 = ci; sub0 = s; in_valid0 = 1'b1;
        w = 0;
        @(negedge clk);
        while (!in_ready0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready0) begin
            fail_now("dut0_accept_timeout");
        end else begin
            e.sum = 32'(es); e.cout = ec; e.ovf = eo; e.zero = ez;
            e.lat = lat; e.acc = cyc + 1; e.seen = 1'b0;
            q0.push_back(e);
        end
        @(posedge clk); #1;
        in_valid0 = 1'b0;
    endtask

    task automatic send1(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic s,
                         input logic [31:0] es, input logic ec, input logic eo, input logic ez,
                         input bit lat);
        exp_t e;
        int   w;
        a1 = a; b1 = b; cin1 = ci; sub1 = s; in_valid1 = 1'b1;
        w = 0;
        @(negedge clk);
        while (!in_ready1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready1) begin
            fail_now("dut1_accept_timeout");
        end else begin
            e.sum = es; e.cout = ec; e.ovf = eo; e.zero = ez;
            e.lat = lat; e.acc = cyc + 1; e.seen = 1'b0;
            q1.push_back(e);
        end
        @(posedge clk); #1;
        in_valid1 = 1'b0;
    endtask

    // Behavioural reference for the random run: plain wide addition.
    task automatic send1_model(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic s);
        logic [31:0] bx;
        logic [32:0] t;
        logic        eo;
        bx = s ? ~b : b;
        t  = {1'b0, a} + {1'b0, bx} + 33'(s | ci);
        eo = (a[31] == bx[31]) && (t[31] != a[31]);
        send1(a, b, ci, s, t[31:0], t[32], eo, (t[31:0] == 32'h0), 1'b0);
    endtask

    task automatic drain(input string name);
        int w;
        w = 0;
        while ((q0.size() != 0 || q1.size() != 0) && w < 200) begin
            @(posedge clk);
            w++;
        end
        #1;
        check(name, 32'(q0.size() + q1.size()), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int w;
        rst = 1'b1;
        in_valid0 = 1'b0; a0 = '0; b0 = '0; cin0 = 1'b0; sub0 = 1'b0; out_ready0 = 1'b1;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0; out_ready1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid0", 32'(out_valid0), 32'd0);
        check("rst_sum0",       32'(sum0),       32'd0);
        check("rst_cout0",      32'(cout0),      32'd0);
        check("rst_ovf0",       32'(ovf0),       32'd0);
        check("rst_zero0",      32'(zero0),      32'd0);
        check("rst_in_ready0",  32'(in_ready0),  32'd1);
        check("rst_out_valid1", 32'(out_valid1), 32'd0);
        check("rst_in_ready1",  32'(in_ready1),  32'd1);
        @(posedge clk); #1;

        // Directed 16-bit vectors: a, b, cin, sub -> sum, cout, ovf, zero
        send0(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
        send0(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
        send0(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        send0(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0, 1'b1);
        send0(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1);
        send0(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b1);
        send0(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b1);
        send0(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b1);
        send0(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
        drain("drain_directed0");

        // Back-to-back transfers with a 3-cycle output stall
        fork
            begin
                send0(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
                send0(16'h0002, 16'h0002, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0);
                send0(16'h0003, 16'h0003, 1'b0, 1'b0, 16'h0006, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            begin
                w = 0;
                while (!out_valid0 && w < 20) begin
                    @(posedge clk); #1;
                    w++;
                end
                if (!out_valid0) fail_now("stall_first_valid_timeout");
                out_ready0 = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_in_ready0", 32'(in_ready0), 32'd0);
                    check("stall_hold_sum0", 32'(sum0), 32'h0002);
                    @(posedge clk); #1;
                end
                out_ready0 = 1'b1;
            end
        join
        drain("drain_stall0");

        // Reset with two transactions in flight
        out_ready0 = 1'b0;
        send0(16'h1111, 16'h1111, 1'b0, 1'b0, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b0);
        send0(16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        q0.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("flush_out_valid0", 32'(out_valid0), 32'd0);
        check("flush_in_ready0",  32'(in_ready0),  32'd1);
        out_ready0 = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        send0(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b1);
        drain("drain_after_flush0");

        // Directed 32-bit / 4-stage vectors
        send1(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1);
        send1(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
        send1(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b1);
        send1(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        drain("drain_directed1");

        // Random operands with random bubbles and output back-pressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid1 = 1'b0;
                a1 = $urandom;
                b1 = $urandom;
                @(posedge clk); #1;
            end
            send1_model($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rand_rdy = 1'b0;
        @(negedge clk);
        out_ready1 = 1'b1;
        drain("drain_random1");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_cla_adder.md
PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; SHALL be a multiple of 4 and of STAGES*4.
REQ-002 Parameter STAGES, default 2, number of pipeline stages; SHALL be 1..WIDTH/4.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port in_valid  input  1  operands a, b, cin, sub are valid this cycle.
REQ-006 Port in_ready  output  1  block accepts operands this cycle.
REQ-007 Port a  input  WIDTH  operand A.
REQ-008 Port b  input  WIDTH  operand B.
REQ-009 Port cin  input  1  carry-in; ignored when sub=1.
REQ-010 Port sub  input  1  0: A+B+cin; 1: A-B, computed as A+~B+1.
REQ-011 Port out_valid  output  1  result fields valid.
REQ-012 Port out_ready  input  1  consumer accepts result this cycle.
REQ-013 Port sum  output  WIDTH  result bits.
REQ-014 Port cout  output  1  carry out of MSB (sub: 1 = no borrow).
REQ-015 Port ovf  output  1  two's-complement signed overflow.
REQ-016 Port zero  output  1  sum == 0.

Function
REQ-017 Slice width SW = WIDTH/STAGES; stage k SHALL add bits [k*SW +: SW] using the registered carry from stage k-1 (stage 0 uses effective carry-in).
REQ-018 Within each slice, carries SHALL be produced by 4-bit carry-lookahead groups chained by group carry-out; no ripple across individual bits.
REQ-019 Operand bits for stage k SHALL be delayed k cycles; finished low slices SHALL be carried forward so all slices align at the output.
REQ-020 Pipeline advance en = !out_valid | out_ready; in_ready SHALL equal en; a transfer occurs when in_valid & in_ready.
REQ-021 When en=0 every stage register, including valid bits, SHALL hold; when en=1 all stages shift by one.
REQ-022 Latency SHALL be exactly STAGES cycles from accepted transfer to out_valid when out_ready stays high; throughput one result per cycle.
REQ-023 Results SHALL emerge in acceptance order; no loss or duplication under arbitrary out_ready stalls.
REQ-024 ovf SHALL equal carry into MSB XOR carry out of MSB; zero SHALL be computed in the final stage.
REQ-025 Bubbles (in_valid=0 while en=1) SHALL propagate as valid=0 stages; sum/cout/ovf/zero are don't-care while out_valid=0.

Reset
REQ-026 While rst=1 at a clock edge, all stage valid bits and out_valid SHALL clear to 0; sum, cout, ovf, zero SHALL clear to 0.
REQ-027 rst asserted with transactions in flight SHALL discard them; no result from before reset SHALL appear afterwards.
REQ-028 in_ready SHALL be 1 the cycle after rst deasserts (pipeline empty).

Structure
REQ-029 Shared package pipe_cla_pkg SHALL hold CLA_GROUP=4, default WIDTH and STAGES, and the parameter legality check.
REQ-030 One sub-module cla_group: combinational 4-bit group (g, p, cin -> per-bit carries, group G/P), instantiated SW/4 times per stage.
REQ-031 Illegal WIDTH/STAGES combinations SHALL fail elaboration.

Verification (WIDTH=16, STAGES=2 unless stated)
REQ-032 a=0xFFFF, b=0x0001, cin=0, sub=0, out_ready=1 -> 2 cycles later out_valid=1, sum=0x0000, cout=1, ovf=0, zero=1.
REQ-033 a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, cout=0, ovf=1, zero=0; a=0x0005, b=0x0007, sub=1, cin=1 -> sum=0xFFFE, cout=0, ovf=0.
REQ-034 Three back-to-back transfers (1+1, 2+2, 3+3), out_ready=0 for 3 cycles after first out_valid -> in_ready=0, outputs hold 0x0002; on release 0x0002, 0x0004, 0x0006 in order.
REQ-035 Two transfers in flight, rst=1 one cycle -> out_valid=0 next edge; neither result ever appears; in_ready=1 after release.
REQ-036 WIDTH=32, STAGES=4: 10k random operands/sub/cin with random in_valid/out_ready -> every result matches behavioural model, latency 4 when unstalled.
